// File: rtl/fplib_clip_pkg.sv
// Shared helpers for the clip/round stream: output code limits and the
// width of a rounded intermediate value.
package fplib_clip_pkg;

  function automatic int rnd_width(input int inw, input int shift);
    return inw - shift + 1;
  endfunction

  function automatic logic signed [63:0] smax_code(input int outw);
    return (64'sd1 <<< (outw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] smin_code(input int outw);
    return -(64'sd1 <<< (outw - 1));
  endfunction

  function automatic logic signed [63:0] umax_code(input int outw);
    return (64'sd1 <<< outw) - 64'sd1;
  endfunction

endpackage

// File: rtl/clip_round_stream_if.sv
// Streaming bus of the word-length reducer: input beat side and output beat side.
interface clip_round_stream_if #(
  parameter int nch  = 2,
  parameter int inw  = 24,
  parameter int outw = 16
);
  // A beat moves on a side in any cycle where its valid and ready are both 1.
  // valid must not depend on ready; once raised, valid and data hold until taken.
  logic                 in_valid;
  logic                 in_ready;
  logic [nch*inw-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [nch*outw-1:0]  out_data;
  logic [nch-1:0]       out_clip;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_clip
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_clip
  );
endinterface

// File: rtl/clip_round_lane.sv
// One channel: round-half-up right shift of the raw input, and saturation of a
// previously rounded value to outw bits. The two paths are independent.
module clip_round_lane
  import fplib_clip_pkg::*;
#(
  parameter int inw       = 24,
  parameter int outw      = 16,
  parameter int shift     = 0,
  parameter bit is_signed = 1'b1
) (
  input  logic [inw-1:0]     din_i,
  output logic [inw-shift:0] rnd_o,
  input  logic [inw-shift:0] rnd_i,
  output logic [outw-1:0]    dout_o,
  output logic               clip_o
);
  localparam int SA = (shift > 0) ? shift - 1 : 0;
  localparam logic [inw:0] HALF = (shift > 0) ? ((inw + 1)'(1) << SA) : '0;
  localparam logic signed [63:0] SMAX = smax_code(outw);
  localparam logic signed [63:0] SMIN = smin_code(outw);
  localparam logic signed [63:0] UMAX = umax_code(outw);

  logic [inw:0]        ext;
  logic [inw:0]        biased;
  logic signed [63:0]  wide;

  // One guard bit above the input keeps the rounding carry from wrapping.
  always_comb begin
    ext    = is_signed ? {din_i[inw-1], din_i} : {1'b0, din_i};
    biased = ext + HALF;
    if (is_signed) rnd_o = (inw - shift + 1)'($signed(biased) >>> shift);
    else           rnd_o = (inw - shift + 1)'(biased >> shift);
  end

  always_comb begin
    if (is_signed) wide = 64'($signed(rnd_i));
    else           wide = 64'(rnd_i);
    dout_o = rnd_i[outw-1:0];
    clip_o = 1'b0;
    if (is_signed) begin
      if (wide > SMAX) begin
        dout_o = SMAX[outw-1:0];
        clip_o = 1'b1;
      end else if (wide < SMIN) begin
        dout_o = SMIN[outw-1:0];
        clip_o = 1'b1;
      end
    end else if (wide > UMAX) begin
      dout_o = UMAX[outw-1:0];
      clip_o = 1'b1;
    end
  end
endmodule

// File: rtl/clip_round_stream.sv
// Multi-channel round-then-saturate stream: round register, clip register,
// shared valid/ready handshake and per-channel clip statistics.
module clip_round_stream
  import fplib_clip_pkg::*;
#(
  parameter int nch       = 2,
  parameter int inw       = 24,
  parameter int outw      = 16,
  parameter int shift     = 0,
  parameter bit is_signed = 1'b1,
  parameter int cntw      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clip_round_stream_if.slave   bus,
  input  logic                 clr_stats,
  output logic [nch-1:0]       clip_sticky,
  output logic [nch*cntw-1:0]  clip_count
);
  localparam int RW = rnd_width(inw, shift);
  localparam logic [cntw-1:0] CNT_MAX = '1;

  logic                 s1_valid_q;
  logic [nch*RW-1:0]    s1_data_q, s1_data_d;
  logic                 s2_valid_q;
  logic [nch*outw-1:0]  s2_data_q, s2_data_d;
  logic [nch-1:0]       s2_clip_q, s2_clip_d;
  logic [nch-1:0]       sticky_q, sticky_d;
  logic [nch*cntw-1:0]  count_q, count_d;
  logic                 s1_adv, s2_adv, out_fire;

  for (genvar k = 0; k < nch; k++) begin : g_lane
    clip_round_lane #(
      .inw(inw), .outw(outw), .shift(shift), .is_signed(is_signed)
    ) u_lane (
      .din_i (bus.in_data[k*inw +: inw]),
      .rnd_o (s1_data_d[k*RW +: RW]),
      .rnd_i (s1_data_q[k*RW +: RW]),
      .dout_o(s2_data_d[k*outw +: outw]),
      .clip_o(s2_clip_d[k])
    );
  end

  // Empty stages always take a beat, so bubbles collapse.
  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign out_fire     = s2_valid_q && bus.out_ready;
  assign bus.in_ready = s1_adv;

  always_comb begin
    logic ev;
    ev       = 1'b0;
    sticky_d = sticky_q;
    count_d  = count_q;
    for (int k = 0; k < nch; k++) begin
      ev = out_fire && s2_clip_q[k];
      if (clr_stats) begin
        sticky_d[k]                = ev;
        count_d[k*cntw +: cntw]    = ev ? cntw'(1) : '0;
      end else if (ev) begin
        sticky_d[k] = 1'b1;
        if (count_q[k*cntw +: cntw] != CNT_MAX)
          count_d[k*cntw +: cntw] = count_q[k*cntw +: cntw] + cntw'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_clip_q  <= '0;
      sticky_q   <= '0;
      count_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) s1_data_q <= s1_data_d;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s2_data_d;
          s2_clip_q <= s2_clip_d;
        end
      end
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_clip  = s2_clip_q;
  assign clip_sticky   = sticky_q;
  assign clip_count    = count_q;
endmodule

// File: tb/tb_clip_round_stream.sv
// Directed bench for clip_round_stream: three configurations (signed shift 4,
// unsigned shift 0, signed with 2-bit counters) sharing one clock and reset.
module tb_clip_round_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  in_valid_v, out_ready_v, clr_v;
  logic [47:0] in_data_v;
  int          sel;
  int          checks = 0;
  int          errors = 0;

  clip_round_stream_if #(.nch(2), .inw(24), .outw(16)) ifa ();
  clip_round_stream_if #(.nch(2), .inw(24), .outw(16)) ifb ();
  clip_round_stream_if #(.nch(2), .inw(24), .outw(16)) ifc ();

  assign ifa.in_valid  = in_valid_v[0];
  assign ifa.in_data   = in_data_v;
  assign ifa.out_ready = out_ready_v[0];
  assign ifb.in_valid  = in_valid_v[1];
  assign ifb.in_data   = in_data_v;
  assign ifb.out_ready = out_ready_v[1];
  assign ifc.in_valid  = in_valid_v[2];
  assign ifc.in_data   = in_data_v;
  assign ifc.out_ready = out_ready_v[2];

  logic [1:0]  sticky_a, sticky_b, sticky_c;
  logic [31:0] count_a, count_b;
  logic [3:0]  count_c;

  clip_round_stream #(.nch(2), .inw(24), .outw(16), .shift(4), .is_signed(1'b1), .cntw(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .clr_stats(clr_v[0]),
    .clip_sticky(sticky_a), .clip_count(count_a)
  );
  clip_round_stream #(.nch(2), .inw(24), .outw(16), .shift(0), .is_signed(1'b0), .cntw(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .clr_stats(clr_v[1]),
    .clip_sticky(sticky_b), .clip_count(count_b)
  );
  clip_round_stream #(.nch(2), .inw(24), .outw(16), .shift(0), .is_signed(1'b1), .cntw(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc), .clr_stats(clr_v[2]),
    .clip_sticky(sticky_c), .clip_count(count_c)
  );

  logic        obs_in_ready, obs_out_valid;
  logic [31:0] obs_data, obs_cnt;
  logic [1:0]  obs_clip, obs_sticky;

  always_comb begin
    case (sel)
      1: begin
        obs_in_ready = ifb.in_ready;  obs_out_valid = ifb.out_valid;
        obs_data = ifb.out_data;      obs_clip = ifb.out_clip;
        obs_sticky = sticky_b;        obs_cnt = count_b;
      end
      2: begin
        obs_in_ready = ifc.in_ready;  obs_out_valid = ifc.out_valid;
        obs_data = ifc.out_data;      obs_clip = ifc.out_clip;
        obs_sticky = sticky_c;        obs_cnt = {28'd0, count_c};
      end
      default: begin
        obs_in_ready = ifa.in_ready;  obs_out_valid = ifa.out_valid;
        obs_data = ifa.out_data;      obs_clip = ifa.out_clip;
        obs_sticky = sticky_a;        obs_cnt = count_a;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated beat through the selected instance with out_ready held high.
  task automatic beat(input string tag, input logic [47:0] din, input logic [31:0] exp_d,
                      input logic [1:0] exp_c, input logic do_clr);
    in_data_v = din;
    in_valid_v[sel] = 1'b1;
    #1;
    chk({tag, ".rdy"}, obs_in_ready, 1);
    @(posedge clk); #1;
    in_valid_v = '0;
    #1;
    chk({tag, ".lat"}, obs_out_valid, 0);
    @(posedge clk); #2;
    chk({tag, ".vld"}, obs_out_valid, 1);
    chk({tag, ".data"}, obs_data, exp_d);
    chk({tag, ".clip"}, obs_clip, exp_c);
    clr_v[sel] = do_clr;
    @(posedge clk); #1;
    clr_v = '0;
    #1;
  endtask

  logic [47:0] bp_din [5];
  logic [31:0] exp_q [$];
  logic [31:0] held, exp_w;
  logic        holding;
  int          sent;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid_v = '0; out_ready_v = '0; clr_v = '0; in_data_v = '0; sel = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.out_valid", obs_out_valid, 0);
    chk("rst.out_data", obs_data, 0);
    chk("rst.out_clip", obs_clip, 0);
    chk("rst.sticky", obs_sticky, 0);
    chk("rst.count", obs_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst.in_ready", obs_in_ready, 1);

    // Signed, shift 4: rounding half-up and the saturation boundaries.
    out_ready_v = 3'b111;
    beat("a1", {24'hFFFFE8, 24'h000017}, 32'hFFFF0001, 2'b00, 1'b0);
    beat("a2", {24'h000008, 24'hFFFFF8}, 32'h00010000, 2'b00, 1'b0);
    beat("a3", {24'h07FFF7, 24'h07FFF8}, 32'h7FFF7FFF, 2'b01, 1'b0);
    chk("a3.count", obs_cnt, 32'h0000_0001);
    chk("a3.sticky", obs_sticky, 2'b01);
    beat("a4", {24'hF80000, 24'h800000}, 32'h80008000, 2'b01, 1'b0);
    chk("a4.count", obs_cnt, 32'h0000_0002);
    chk("a4.sticky", obs_sticky, 2'b01);

    // Backpressure: five beats back to back, out_ready low in cycles 3..5.
    bp_din = '{{24'hFFFFF0, 24'h000010}, {24'hFFFFE0, 24'h000020}, {24'hFFFFD0, 24'h000030},
               {24'hFFFFC0, 24'h000040}, {24'hFFFFB0, 24'h000050}};
    exp_q = '{32'hFFFF0001, 32'hFFFE0002, 32'hFFFD0003, 32'hFFFC0004, 32'hFFFB0005};
    sent = 0; holding = 1'b0; held = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready_v[0] = !(cyc >= 3 && cyc <= 5);
      in_valid_v[0]  = (sent < 5);
      in_data_v      = bp_din[(sent < 5) ? sent : 4];
      #1;
      chk("bp.in_ready", obs_in_ready, (cyc >= 3 && cyc <= 5) ? 0 : 1);
      if (holding) begin
        chk("bp.hold_valid", obs_out_valid, 1);
        chk("bp.hold_data", obs_data, held);
      end
      if (obs_out_valid && out_ready_v[0]) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        chk("bp.data", obs_data, exp_w);
      end
      holding = obs_out_valid && !out_ready_v[0];
      held    = obs_data;
      if (in_valid_v[0] && obs_in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid_v = '0;
    out_ready_v = 3'b111;
    #1;
    chk("bp.sent", sent, 5);
    chk("bp.drained", exp_q.size(), 0);
    chk("bp.count", obs_cnt, 32'h0000_0002);

    // Unsigned, shift 0.
    sel = 1;
    beat("b1", {24'h00FFFF, 24'h010000}, 32'hFFFFFFFF, 2'b01, 1'b0);
    chk("b1.count", obs_cnt, 32'h0000_0001);
    beat("b2", {24'h001234, 24'h800000}, 32'h1234FFFF, 2'b01, 1'b0);
    chk("b2.count", obs_cnt, 32'h0000_0002);
    chk("b2.sticky", obs_sticky, 2'b01);

    // Signed, shift 0, 2-bit counters: saturation and clear-with-event.
    sel = 2;
    beat("c1", {24'hFF8000, 24'h008000}, 32'h80007FFF, 2'b01, 1'b0);
    beat("c2", {24'hFF7FFF, 24'h008000}, 32'h80007FFF, 2'b11, 1'b0);
    beat("c3", {24'h000000, 24'h008000}, 32'h00007FFF, 2'b01, 1'b0);
    chk("c3.count", obs_cnt, 32'h7);
    beat("c4", {24'h000000, 24'h008000}, 32'h00007FFF, 2'b01, 1'b0);
    beat("c5", {24'h000000, 24'h008000}, 32'h00007FFF, 2'b01, 1'b0);
    chk("c5.count_sat", obs_cnt, 32'h7);
    chk("c5.sticky", obs_sticky, 2'b11);
    beat("c6", {24'h000000, 24'h008000}, 32'h00007FFF, 2'b01, 1'b1);
    chk("c6.count_clr_ev", obs_cnt, 32'h1);
    chk("c6.sticky_clr_ev", obs_sticky, 2'b01);
    clr_v[2] = 1'b1;
    @(posedge clk); #1;
    clr_v = '0;
    #1;
    chk("c7.count_clr", obs_cnt, 32'h0);
    chk("c7.sticky_clr", obs_sticky, 2'b00);

    // Reset with both stages of A full.
    sel = 0;
    out_ready_v = '0;
    in_valid_v[0] = 1'b1;
    in_data_v = {24'h000000, 24'h000010};
    @(posedge clk); #1;
    in_data_v = {24'h000000, 24'h000020};
    @(posedge clk); #1;
    in_valid_v = '0;
    #1;
    chk("full.out_valid", obs_out_valid, 1);
    chk("full.out_data", obs_data, 32'h0000_0001);
    chk("full.in_ready", obs_in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", obs_out_valid, 0);
    chk("mrst.out_data", obs_data, 0);
    chk("mrst.count", obs_cnt, 0);
    chk("mrst.sticky", obs_sticky, 0);
    sel = 1;
    #1;
    chk("mrst.count_b", obs_cnt, 0);
    sel = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready_v = 3'b111;
    @(posedge clk); #2;
    chk("post.in_ready", obs_in_ready, 1);
    chk("post.out_valid", obs_out_valid, 0);
    @(posedge clk); #2;
    chk("post.no_ghost", obs_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
